// File: rtl/memory_access_pkg.sv
// Memory-stage shared definitions: opcode and funct3 encodings, `OPCODE_WIDTH,
// and the natural-alignment helper used when MEM_MISALIGN_CHECK_EN is defined.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif

package memory_access_pkg;
  localparam int OPC_W = `OPCODE_WIDTH;

  localparam logic [OPC_W-1:0] OPC_LOAD  = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(7'b0100011);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic is_ld, input logic is_st,
                                         input logic [2:0] f3, input logic [1:0] lo);
    logic half, word;
    half = (is_ld && (f3 == F3_LH || f3 == F3_LHU)) || (is_st && f3 == F3_SH);
    word = (is_ld || is_st) && (f3 == F3_LW);
    return (half && lo[0]) || (word && lo != 2'b00);
  endfunction
endpackage

// File: rtl/memory_access_if.sv
// Memory-stage pipeline + data-bus signal bundle.
// master: the memory stage; slave: execute/writeback/data-memory side.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif

interface memory_access_if #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int PC_WIDTH    = 32
);
  import memory_access_pkg::*;

  logic                     ms_i_ce, ms_i_stall, ms_i_flush;
  logic [`OPCODE_WIDTH-1:0] ms_i_opcode;
  logic [FUNCT_WIDTH-1:0]   ms_i_funct3;
  logic [DWIDTH-1:0]        ms_i_alu_result, ms_i_rs2_data;
  logic [AWIDTH-1:0]        ms_i_addr_rd;
  logic [PC_WIDTH-1:0]      ms_i_next_pc;
  logic                     ms_o_ce, ms_o_stall;
  logic [`OPCODE_WIDTH-1:0] ms_o_opcode;
  logic [FUNCT_WIDTH-1:0]   ms_o_funct3;
  logic [DWIDTH-1:0]        ms_o_data_rd;
  logic [AWIDTH-1:0]        ms_o_addr_rd;
  logic [PC_WIDTH-1:0]      ms_o_next_pc;
  logic                     ms_o_misaligned;
  logic                     ms_o_req, ms_o_we;
  logic [3:0]               ms_o_sel;
  logic [DWIDTH-1:0]        ms_o_addr, ms_o_wdata;
  logic                     ms_i_ack;
  logic [DWIDTH-1:0]        ms_i_rdata;

  modport master (
    input  ms_i_ce, ms_i_stall, ms_i_flush, ms_i_opcode, ms_i_funct3, ms_i_alu_result,
           ms_i_rs2_data, ms_i_addr_rd, ms_i_next_pc, ms_i_ack, ms_i_rdata,
    output ms_o_ce, ms_o_stall, ms_o_opcode, ms_o_funct3, ms_o_data_rd, ms_o_addr_rd,
           ms_o_next_pc, ms_o_misaligned, ms_o_req, ms_o_we, ms_o_sel, ms_o_addr, ms_o_wdata
  );

  modport slave (
    output ms_i_ce, ms_i_stall, ms_i_flush, ms_i_opcode, ms_i_funct3, ms_i_alu_result,
           ms_i_rs2_data, ms_i_addr_rd, ms_i_next_pc, ms_i_ack, ms_i_rdata,
    input  ms_o_ce, ms_o_stall, ms_o_opcode, ms_o_funct3, ms_o_data_rd, ms_o_addr_rd,
           ms_o_next_pc, ms_o_misaligned, ms_o_req, ms_o_we, ms_o_sel, ms_o_addr, ms_o_wdata
  );
endinterface

// File: rtl/memory_access_load_align.sv
// load_align: picks the addressed byte/half out of a read word and extends it.
module load_align
  import memory_access_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic [FUNCT_WIDTH-1:0] funct3,
  input  logic [1:0]             addr_lo,
  input  logic [DWIDTH-1:0]      rdata,
  output logic [DWIDTH-1:0]      data
);
  localparam int NUM_LANES = DWIDTH / 8;

  logic [NUM_LANES-1:0][7:0] rbytes;
  logic [7:0]                b;
  logic [15:0]               h;

  assign rbytes = rdata;
  assign b      = rbytes[addr_lo];
  // Halves come from the upper or lower pair; addr[0] is ignored here.
  assign h      = {rbytes[{addr_lo[1], 1'b1}], rbytes[{addr_lo[1], 1'b0}]};

  // Extension by funct3; LW and anything unknown pass the word through.
  always_comb begin
    case (funct3)
      F3_LB:   data = {{(DWIDTH-8){b[7]}}, b};
      F3_LH:   data = {{(DWIDTH-16){h[15]}}, h};
      F3_LBU:  data = {{(DWIDTH-8){1'b0}}, b};
      F3_LHU:  data = {{(DWIDTH-16){1'b0}}, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/memory_access.sv
// memory_access: memory stage. ALU ops pass through in one cycle; loads and
// stores issue one data-bus request and stall upstream until it is acked.
// Optional MEM_MISALIGN_CHECK_EN: misaligned LH/LHU/SH/LW/SW are trapped
// (ms_o_misaligned) instead of going to the bus.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif

module memory_access
  import memory_access_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int PC_WIDTH    = 32
) (
  input logic            ms_clk,
  input logic            ms_rst,
  memory_access_if.master ms
);
  localparam int NUM_LANES = DWIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic                   ce;
    logic [OPC_W-1:0]       opcode;
    logic [FUNCT_WIDTH-1:0] funct3;
    logic [DWIDTH-1:0]      data_rd;
    logic [AWIDTH-1:0]      addr_rd;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   misaligned;
  } wb_t;

  typedef struct packed {
    logic                 req;
    logic                 we;
    logic [NUM_LANES-1:0] sel;
    logic [DWIDTH-1:0]    addr;
    logic [DWIDTH-1:0]    wdata;
  } bus_t;

  state_t     state_q, state_d;
  wb_t        wb_q, wb_d;
  bus_t       bus_q, bus_d;
  logic       kill_q, kill_d;   // flush seen while the access was in flight
  logic [1:0] lo_q, lo_d;       // byte offset kept for load extraction

  logic       is_ld, is_st, mis_acc;
  logic [2:0] f3;
  logic [1:0] lo;
  logic [DWIDTH-1:0] ld_data;
  logic [NUM_LANES-1:0]      st_sel;
  logic [NUM_LANES-1:0][7:0] st_bytes, rs2_bytes;

  assign is_ld     = (ms.ms_i_opcode == OPC_LOAD);
  assign is_st     = (ms.ms_i_opcode == OPC_STORE);
  assign f3        = ms.ms_i_funct3;
  assign lo        = ms.ms_i_alu_result[1:0];
  assign rs2_bytes = ms.ms_i_rs2_data;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_acc = is_misaligned(is_ld, is_st, f3, lo);
`else
  assign mis_acc = 1'b0;
`endif

  // Store lane enables and replicated write data; loads enable every lane.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign st_sel[l]   = !is_st           ? 1'b1 :
                         (f3 == F3_SB)    ? (lo == 2'(l)) :
                         (f3 == F3_SH)    ? (lo[1] == 1'(l / 2)) : 1'b1;
    assign st_bytes[l] = (f3 == F3_SB)    ? rs2_bytes[0] :
                         (f3 == F3_SH)    ? rs2_bytes[l % 2] : rs2_bytes[l];
  end

  load_align #(.DWIDTH(DWIDTH), .FUNCT_WIDTH(FUNCT_WIDTH)) u_load_align (
    .funct3  (wb_q.funct3),
    .addr_lo (lo_q),
    .rdata   (ms.ms_i_rdata),
    .data    (ld_data)
  );

  // Next-state / next-output logic for the IDLE-WAIT-HOLD sequencer.
  always_comb begin
    state_d = state_q;
    wb_d    = wb_q;
    bus_d   = bus_q;
    kill_d  = kill_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (ms.ms_i_flush) begin
          wb_d.ce = 1'b0;
        end else if (!ms.ms_i_stall) begin
          wb_d.ce         = 1'b0;
          wb_d.misaligned = 1'b0;
          if (ms.ms_i_ce) begin
            wb_d.opcode  = ms.ms_i_opcode;
            wb_d.funct3  = ms.ms_i_funct3;
            wb_d.addr_rd = ms.ms_i_addr_rd;
            wb_d.next_pc = ms.ms_i_next_pc;
            wb_d.data_rd = ms.ms_i_alu_result;
            lo_d         = lo;
            kill_d       = 1'b0;
            if (mis_acc) begin
              wb_d.ce         = 1'b1;
              wb_d.misaligned = 1'b1;
            end else if (is_ld || is_st) begin
              bus_d.req   = 1'b1;
              bus_d.we    = is_st;
              bus_d.sel   = st_sel;
              bus_d.addr  = {ms.ms_i_alu_result[DWIDTH-1:2], 2'b00};
              bus_d.wdata = st_bytes;
              state_d     = WAIT;
            end else begin
              wb_d.ce = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        kill_d = kill_q | ms.ms_i_flush;
        if (ms.ms_i_ack) begin
          bus_d        = '0;
          wb_d.data_rd = bus_q.we ? '0 : ld_data;
          if (kill_q || ms.ms_i_flush) state_d = IDLE;
          else if (ms.ms_i_stall)      state_d = HOLD;
          else begin
            wb_d.ce = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        kill_d = kill_q | ms.ms_i_flush;
        if (!ms.ms_i_stall) begin
          wb_d.ce = !(kill_q || ms.ms_i_flush);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge ms_clk) begin
    if (ms_rst) begin
      state_q <= IDLE;
      wb_q    <= '0;
      bus_q   <= '0;
      kill_q  <= 1'b0;
      lo_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      bus_q   <= bus_d;
      kill_q  <= kill_d;
      lo_q    <= lo_d;
    end
  end

  assign ms.ms_o_ce          = wb_q.ce;
  // Downstream stall is forwarded so upstream also holds while IDLE is blocked.
  assign ms.ms_o_stall       = (state_q != IDLE) || ms.ms_i_stall;
  assign ms.ms_o_opcode      = wb_q.opcode;
  assign ms.ms_o_funct3      = wb_q.funct3;
  assign ms.ms_o_data_rd     = wb_q.data_rd;
  assign ms.ms_o_addr_rd     = wb_q.addr_rd;
  assign ms.ms_o_next_pc     = wb_q.next_pc;
  assign ms.ms_o_misaligned  = wb_q.misaligned;
  assign ms.ms_o_req         = bus_q.req;
  assign ms.ms_o_we          = bus_q.we;
  assign ms.ms_o_sel         = bus_q.sel;
  assign ms.ms_o_addr        = bus_q.addr;
  assign ms.ms_o_wdata       = bus_q.wdata;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vector table, hand-written multi-cycle sequences
// and random loads/stores/ALU ops against a transaction-level model.
module tb_memory_access;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu, rs2, rdata, pc;
    logic [4:0]  rd;
    int          dly;
    logic [31:0] e_data, e_wdata;
    logic [3:0]  e_sel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  vec_t tbl [10];

  always #5 clk = ~clk;

  memory_access_if ifc ();
  memory_access dut (.ms_clk(clk), .ms_rst(rst), .ms(ifc));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
    ifc.ms_i_ce = 1'b1;  ifc.ms_i_opcode = op; ifc.ms_i_funct3 = f3;
    ifc.ms_i_alu_result = alu; ifc.ms_i_rs2_data = rs2;
    ifc.ms_i_addr_rd = rd; ifc.ms_i_next_pc = pc;
  endtask

  // Reference rules, written straight from the lane/extension definitions.
  function automatic logic [3:0] m_sel(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (st && f3 == 3'd0) return 4'b0001 << a[1:0];
    if (st && f3 == 3'd1) return 4'b0011 << {a[1], 1'b0};
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return {4{d[7:0]}};
    if (f3 == 3'd1) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd4:    return {24'h0, sh[7:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                              input logic [31:0] rs2, input logic [31:0] rdata, input int dly,
                              input logic [31:0] e_data, input logic [3:0] e_sel, input logic [31:0] e_wdata);
    vec_t v;
    v.op = op; v.f3 = f3; v.alu = alu; v.rs2 = rs2; v.rdata = rdata; v.dly = dly;
    v.rd = 5'd5; v.pc = alu + 32'h100;
    v.e_data = e_data; v.e_sel = e_sel; v.e_wdata = e_wdata;
    return v;
  endfunction

  // One instruction end to end: accept, bus phase with optional wait, writeback.
  task automatic run_vec(input vec_t v, input string nm);
    logic mem;
    mem = (v.op == OP_LOAD) || (v.op == OP_STORE);
    drive(v.op, v.f3, v.alu, v.rs2, v.rd, v.pc);
    ifc.ms_i_ack = 1'b0;
    tick();
    ifc.ms_i_ce = 1'b0;
    if (mem) begin
      chk({nm, " req"},   32'(ifc.ms_o_req), 32'd1);
      chk({nm, " we"},    32'(ifc.ms_o_we), 32'(v.op == OP_STORE));
      chk({nm, " sel"},   32'(ifc.ms_o_sel), 32'(v.e_sel));
      chk({nm, " addr"},  ifc.ms_o_addr, v.alu & ~32'd3);
      chk({nm, " ce0"},   32'(ifc.ms_o_ce), 32'd0);
      if (v.op == OP_STORE) chk({nm, " wdata"}, ifc.ms_o_wdata, v.e_wdata);
      for (int i = 0; i < v.dly; i++) begin
        chk({nm, " wait stall"}, 32'(ifc.ms_o_stall), 32'd1);
        chk({nm, " wait req"},   32'(ifc.ms_o_req), 32'd1);
        tick();
      end
      chk({nm, " addr held"}, ifc.ms_o_addr, v.alu & ~32'd3);
      ifc.ms_i_ack = 1'b1; ifc.ms_i_rdata = v.rdata;
      tick();
      ifc.ms_i_ack = 1'b0;
      chk({nm, " req done"}, 32'(ifc.ms_o_req), 32'd0);
      chk({nm, " stall done"}, 32'(ifc.ms_o_stall), 32'd0);
    end else begin
      chk({nm, " no req"}, 32'(ifc.ms_o_req), 32'd0);
    end
    chk({nm, " ce"},      32'(ifc.ms_o_ce), 32'd1);
    chk({nm, " data_rd"}, ifc.ms_o_data_rd, v.e_data);
    chk({nm, " addr_rd"}, 32'(ifc.ms_o_addr_rd), 32'(v.rd));
    chk({nm, " next_pc"}, ifc.ms_o_next_pc, v.pc);
    chk({nm, " opcode"},  32'(ifc.ms_o_opcode), 32'(v.op));
    chk({nm, " funct3"},  32'(ifc.ms_o_funct3), 32'(v.f3));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.ms_i_ce = 1'b0; ifc.ms_i_stall = 1'b0; ifc.ms_i_flush = 1'b0;
    ifc.ms_i_opcode = '0; ifc.ms_i_funct3 = '0; ifc.ms_i_alu_result = '0;
    ifc.ms_i_rs2_data = '0; ifc.ms_i_addr_rd = '0; ifc.ms_i_next_pc = '0;
    ifc.ms_i_ack = 1'b0; ifc.ms_i_rdata = '0;

    tbl[0] = mk(OP_ADD,   3'd0, 32'd100,      32'h0,        32'h0,        0, 32'd100,      4'b1111, 32'h0);
    tbl[1] = mk(OP_LOAD,  3'd0, 32'h1003,     32'h0,        32'h80000000, 3, 32'hFFFFFF80, 4'b1111, 32'h0);
    tbl[2] = mk(OP_STORE, 3'd0, 32'h2001,     32'hAB,       32'h0,        1, 32'h0,        4'b0010, 32'hABABABAB);
    tbl[3] = mk(OP_STORE, 3'd1, 32'h2002,     32'h1234BEEF, 32'h0,        0, 32'h0,        4'b1100, 32'hBEEFBEEF);
    tbl[4] = mk(OP_STORE, 3'd2, 32'h2004,     32'hDEADBEEF, 32'h0,        2, 32'h0,        4'b1111, 32'hDEADBEEF);
    tbl[5] = mk(OP_LOAD,  3'd4, 32'h1001,     32'h0,        32'h1122F344, 1, 32'h000000F3, 4'b1111, 32'h0);
    tbl[6] = mk(OP_LOAD,  3'd1, 32'h1002,     32'h0,        32'h80017FFF, 0, 32'hFFFF8001, 4'b1111, 32'h0);
    tbl[7] = mk(OP_LOAD,  3'd5, 32'h1000,     32'h0,        32'h00009ABC, 2, 32'h00009ABC, 4'b1111, 32'h0);
    tbl[8] = mk(OP_LOAD,  3'd2, 32'h1004,     32'h0,        32'hCAFEF00D, 1, 32'hCAFEF00D, 4'b1111, 32'h0);
    tbl[9] = mk(OP_STORE, 3'd0, 32'h2003,     32'h5A,       32'h0,        0, 32'h0,        4'b1000, 32'h5A5A5A5A);

    // Reset state
    tick(); tick();
    chk("rst ce",    32'(ifc.ms_o_ce), 32'd0);
    chk("rst stall", 32'(ifc.ms_o_stall), 32'd0);
    chk("rst req",   32'(ifc.ms_o_req), 32'd0);
    chk("rst we",    32'(ifc.ms_o_we), 32'd0);
    chk("rst sel",   32'(ifc.ms_o_sel), 32'd0);
    chk("rst addr",  ifc.ms_o_addr, 32'd0);
    chk("rst data",  ifc.ms_o_data_rd, 32'd0);
    chk("rst mis",   32'(ifc.ms_o_misaligned), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Ack under downstream stall parks the result in HOLD
    drive(OP_LOAD, 3'd2, 32'h40, 32'h0, 5'd9, 32'h44);
    tick();
    ifc.ms_i_ce = 1'b0; ifc.ms_i_stall = 1'b1; ifc.ms_i_ack = 1'b1; ifc.ms_i_rdata = 32'h12345678;
    tick();
    ifc.ms_i_ack = 1'b0;
    chk("hold ce0",    32'(ifc.ms_o_ce), 32'd0);
    chk("hold req0",   32'(ifc.ms_o_req), 32'd0);
    chk("hold stall",  32'(ifc.ms_o_stall), 32'd1);
    tick();
    chk("hold ce0b",   32'(ifc.ms_o_ce), 32'd0);
    ifc.ms_i_stall = 1'b0;
    tick();
    chk("hold ce",     32'(ifc.ms_o_ce), 32'd1);
    chk("hold data",   ifc.ms_o_data_rd, 32'h12345678);
    chk("hold rd",     32'(ifc.ms_o_addr_rd), 32'd9);

    // Flush during WAIT: bus still completes, result dropped
    drive(OP_LOAD, 3'd2, 32'h44, 32'h0, 5'd3, 32'h48);
    tick();
    ifc.ms_i_ce = 1'b0; ifc.ms_i_flush = 1'b1;
    tick();
    ifc.ms_i_flush = 1'b0;
    chk("wflush req",  32'(ifc.ms_o_req), 32'd1);
    chk("wflush ce",   32'(ifc.ms_o_ce), 32'd0);
    ifc.ms_i_ack = 1'b1; ifc.ms_i_rdata = 32'h55;
    tick();
    ifc.ms_i_ack = 1'b0;
    chk("wflush done req", 32'(ifc.ms_o_req), 32'd0);
    chk("wflush drop ce",  32'(ifc.ms_o_ce), 32'd0);
    chk("wflush stall",    32'(ifc.ms_o_stall), 32'd0);

    // Ack and flush in the same cycle
    drive(OP_LOAD, 3'd0, 32'h48, 32'h0, 5'd4, 32'h4C);
    tick();
    ifc.ms_i_ce = 1'b0; ifc.ms_i_ack = 1'b1; ifc.ms_i_flush = 1'b1;
    tick();
    ifc.ms_i_ack = 1'b0; ifc.ms_i_flush = 1'b0;
    chk("ackflush ce",  32'(ifc.ms_o_ce), 32'd0);
    chk("ackflush req", 32'(ifc.ms_o_req), 32'd0);

    // Flush in IDLE kills ALU op and load before any request
    drive(OP_ADD, 3'd0, 32'd77, 32'h0, 5'd3, 32'h50);
    ifc.ms_i_flush = 1'b1;
    tick();
    chk("iflush alu ce", 32'(ifc.ms_o_ce), 32'd0);
    drive(OP_LOAD, 3'd2, 32'h50, 32'h0, 5'd3, 32'h54);
    tick();
    chk("iflush ld req",   32'(ifc.ms_o_req), 32'd0);
    chk("iflush ld stall", 32'(ifc.ms_o_stall), 32'd0);
    ifc.ms_i_flush = 1'b0; ifc.ms_i_ce = 1'b0;

    // Downstream stall in IDLE holds outputs
    drive(OP_ADD, 3'd0, 32'd55, 32'h0, 5'd7, 32'h60);
    tick();
    drive(OP_ADD, 3'd0, 32'd99, 32'h0, 5'd8, 32'h64);
    ifc.ms_i_stall = 1'b1;
    tick();
    chk("istall ce",   32'(ifc.ms_o_ce), 32'd1);
    chk("istall data", ifc.ms_o_data_rd, 32'd55);
    chk("istall rd",   32'(ifc.ms_o_addr_rd), 32'd7);
    ifc.ms_i_stall = 1'b0;
    tick();
    chk("istall next data", ifc.ms_o_data_rd, 32'd99);
    ifc.ms_i_ce = 1'b0;
    tick();
    chk("bubble ce", 32'(ifc.ms_o_ce), 32'd0);

    // Reset mid-transaction, late ack ignored
    drive(OP_LOAD, 3'd2, 32'h60, 32'h0, 5'd2, 32'h68);
    tick();
    ifc.ms_i_ce = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst req",   32'(ifc.ms_o_req), 32'd0);
    chk("mrst stall", 32'(ifc.ms_o_stall), 32'd0);
    chk("mrst addr",  ifc.ms_o_addr, 32'd0);
    ifc.ms_i_ack = 1'b1; ifc.ms_i_rdata = 32'hFFFF;
    tick();
    ifc.ms_i_ack = 1'b0;
    chk("late ack ce",   32'(ifc.ms_o_ce), 32'd0);
    chk("late ack data", ifc.ms_o_data_rd, 32'd0);

    // Misaligned word store at 0x3002
    drive(OP_STORE, 3'd2, 32'h3002, 32'h11223344, 5'd0, 32'h70);
    tick();
    ifc.ms_i_ce = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis flag", 32'(ifc.ms_o_misaligned), 32'd1);
    chk("mis ce",   32'(ifc.ms_o_ce), 32'd1);
    chk("mis req",  32'(ifc.ms_o_req), 32'd0);
    tick();
    chk("mis clear", 32'(ifc.ms_o_misaligned), 32'd0);
`else
    chk("mis flag0", 32'(ifc.ms_o_misaligned), 32'd0);
    chk("mis req1",  32'(ifc.ms_o_req), 32'd1);
    chk("mis sel",   32'(ifc.ms_o_sel), 32'hF);
    chk("mis addr",  ifc.ms_o_addr, 32'h3000);
    ifc.ms_i_ack = 1'b1;
    tick();
    ifc.ms_i_ack = 1'b0;
    chk("mis ce",    32'(ifc.ms_o_ce), 32'd1);
`endif

    // Random traffic against the model (natural alignment for half/word)
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int k;
      k = $urandom_range(0, 2);
      v.alu = $urandom; v.rs2 = $urandom; v.rdata = $urandom;
      v.rd = 5'($urandom); v.pc = $urandom; v.dly = $urandom_range(0, 3);
      if (k == 0) begin
        v.op = OP_ADD; v.f3 = 3'($urandom); v.e_data = v.alu;
      end else if (k == 1) begin
        v.op = OP_LOAD; v.f3 = ld_f3[$urandom_range(0, 4)];
      end else begin
        v.op = OP_STORE; v.f3 = 3'($urandom_range(0, 2));
      end
      if (k != 0 && v.f3[1:0] == 2'd1) v.alu[0] = 1'b0;
      if (k != 0 && v.f3 == 3'd2) v.alu[1:0] = 2'b00;
      if (k == 1) v.e_data = m_load(v.f3, v.alu, v.rdata);
      if (k == 2) v.e_data = 32'h0;
      v.e_sel   = m_sel(k == 2, v.f3, v.alu);
      v.e_wdata = m_wdata(v.f3, v.rs2);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameters SHALL be, one per line:
- DWIDTH, 32, data/address width
- AWIDTH, 5, register address width
- FUNCT_WIDTH, 3, funct3 width
- PC_WIDTH, 32, program counter width
REQ-002 Ports SHALL be, one per line. Clock is ms_clk; reset is ms_rst, synchronous and active-high.
- ms_clk  in  1  single clock, rising edge
- ms_rst  in  1  synchronous active-high reset
- ms_i_ce  in  1  upstream (execute) instruction valid
- ms_i_stall  in  1  downstream (writeback) stall
- ms_i_flush  in  1  kill current instruction
- ms_i_opcode  in  `OPCODE_WIDTH  opcode
- ms_i_funct3  in  FUNCT_WIDTH  funct3
- ms_i_alu_result  in  DWIDTH  ALU result / effective address
- ms_i_rs2_data  in  DWIDTH  store data
- ms_i_addr_rd  in  AWIDTH  destination register
- ms_i_next_pc  in  PC_WIDTH  next PC
- ms_o_ce  out  1  valid to writeback
- ms_o_stall  out  1  stall to upstream
- ms_o_opcode  out  `OPCODE_WIDTH  registered opcode
- ms_o_funct3  out  FUNCT_WIDTH  registered funct3
- ms_o_data_rd  out  DWIDTH  load data, or ALU result for non-loads
- ms_o_addr_rd  out  AWIDTH  registered rd
- ms_o_next_pc  out  PC_WIDTH  registered next PC
- ms_o_misaligned  out  1  misaligned access flag
- ms_o_req  out  1  data-memory request, held until ack
- ms_o_we  out  1  write enable
- ms_o_sel  out  4  byte lanes
- ms_o_addr  out  DWIDTH  word-aligned bus address
- ms_o_wdata  out  DWIDTH  lane-replicated store data
- ms_i_ack  in  1  memory acknowledge, one-cycle pulse
- ms_i_rdata  in  DWIDTH  read data, valid with ack

Function
REQ-003 FSM SHALL have states IDLE, WAIT and HOLD; ms_o_stall SHALL be 1 whenever state is not IDLE, and upstream holds its inputs while ms_o_stall is 1.
REQ-004 In IDLE, with ms_i_ce=1, ms_i_stall=0 and ms_i_flush=0:
- Non-load/store: all outputs are registered with ms_o_ce=1 at the next edge (1-cycle latency).
- LOAD/STORE: at the next edge, ms_o_req=1 and ms_o_we=(STORE), ms_o_addr={addr[31:2],2'b00}; state goes to WAIT; ms_o_ce=0.
REQ-005 Lane rules:
- ms_o_sel: SB = 0001<<addr[1:0]; SH = 0011<<{addr[1],1'b0}; SW and all loads = 1111.
- ms_o_wdata: byte replicated x4 (SB), half replicated x2 (SH), word (SW).
REQ-006 In WAIT, ms_o_req and all bus outputs SHALL stay stable until ms_i_ack=1; ms_o_req SHALL be 0 at the edge after ack.
- On ack with ms_i_stall=0: ms_o_ce=1 next edge, return to IDLE.
- On ack with ms_i_stall=1: result captured, go to HOLD; leave HOLD with ms_o_ce=1 at the first edge where ms_i_stall=0.
REQ-007 Load extraction (from ms_i_rdata, selected by addr[1:0]): LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Stores present ms_o_data_rd=0.
REQ-008 While ms_i_stall=1 in IDLE, all outputs SHALL hold and no new instruction is accepted.
REQ-009 Flush:
- In IDLE: ms_o_ce=0 at the next edge and no request is issued.
- In WAIT/HOLD: the bus transaction completes, but its result is dropped (ms_o_ce stays 0). Ack and flush in the same cycle also drops the result.

Reset
REQ-010 With ms_rst=1 at an edge, state=IDLE and every output, including ms_o_req and ms_o_misaligned, is 0. This applies mid-transaction: the request is abandoned, and a late ack is ignored in IDLE.

Configuration
REQ-011 MEM_MISALIGN_CHECK_EN defined:
- LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no request.
- Instead, ms_o_ce=1 and ms_o_misaligned=1 for one cycle (1-cycle latency).
REQ-012 MEM_MISALIGN_CHECK_EN undefined: ms_o_misaligned is tied to 0, and misaligned accesses use the lane rules of REQ-005 unchanged.

Structure
REQ-013 The shared header SHALL hold opcode constants (LOAD, STORE), funct3 encodings (LB..LHU, SB..SW) and `OPCODE_WIDTH; FSM state encodings stay local to memory_access.
REQ-014 Load alignment/extension SHALL be a combinational sub-module named load_align; store lane/sel generation stays inline.

Verification
REQ-015 ADD writing rd=5, result 100 -> next edge: ms_o_ce=1, ms_o_data_rd=100, ms_o_addr_rd=5, no ms_o_req.
REQ-016 LB at addr 0x1003, ms_i_rdata=0x80000000, ack 3 cycles after request -> ms_o_data_rd=0xFFFFFF80, ms_o_stall=1 throughout WAIT.
REQ-017 SB at 0x2001 with rs2=0xAB -> ms_o_sel=0010, ms_o_wdata=0xABABABAB, ms_o_we=1, ms_o_addr=0x2000.
REQ-018 LW acked while ms_i_stall=1 for 2 cycles -> HOLD; ms_o_ce=1 on the first edge after stall drops, with data intact.
REQ-019 Flush asserted during WAIT of LW -> transaction completes on ack, ms_o_ce stays 0; with MEM_MISALIGN_CHECK_EN, SW at 0x3002 -> ms_o_misaligned=1 and no ms_o_req.
